// File: rtl/mem_wb_unit_pkg.sv
// ---------------------------------------------------------------------------
// common
//   Types and helpers shared by the memory/writeback unit and its load
//   extender:
//     op_t    : class of instruction result entering the unit
//     msize_t : access width (byte, half, word, double)
//     state_t : memory/writeback sequencer state
//   Helpers:
//     size_mask     : byte-lane mask of an access before lane alignment
//     is_misaligned : access width vs. low address bits check
// ---------------------------------------------------------------------------
package common;

    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam int XLEN = 64;

    function automatic logic [7:0] size_mask(input msize_t s);
        logic [7:0] m;
        case (s)
            SIZE_B:  m = 8'h01;
            SIZE_H:  m = 8'h03;
            SIZE_W:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input msize_t s, input logic [2:0] off);
        logic mis;
        case (s)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = off[0];
            SIZE_W:  mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_wb_unit_extend.sv
// ---------------------------------------------------------------------------
// mem_extend
//   Combinational load-data extractor: moves the addressed bytes of a 64-bit
//   bus word down to bit 0, keeps only the access width and sign- or
//   zero-extends the result to 64 bits. Doubleword loads pass through.
//   Ports:
//     data_i     : raw 64-bit bus read data
//     offset_i   : byte offset of the access within the bus word
//     size_i     : access width
//     unsigned_i : 1 = zero-extend, 0 = sign-extend
//     result_o   : register-file ready load value
// ---------------------------------------------------------------------------
module mem_extend
    import common::*;
(
    input  logic [63:0] data_i,
    input  logic [2:0]  offset_i,
    input  msize_t      size_i,
    input  logic        unsigned_i,
    output logic [63:0] result_o
);

    logic [63:0] shifted;

    always_comb begin
        shifted  = data_i >> {offset_i, 3'b000};
        result_o = shifted;
        case (size_i)
            SIZE_B: result_o = unsigned_i ? {56'd0, shifted[7:0]}
                                          : {{56{shifted[7]}}, shifted[7:0]};
            SIZE_H: result_o = unsigned_i ? {48'd0, shifted[15:0]}
                                          : {{48{shifted[15]}}, shifted[15:0]};
            SIZE_W: result_o = unsigned_i ? {32'd0, shifted[31:0]}
                                          : {{32{shifted[31]}}, shifted[31:0]};
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_wb_unit.sv
// ---------------------------------------------------------------------------
// mem_wb_unit
//   Memory-access and register writeback stage. Accepts one instruction
//   result at a time; ALU results go straight to writeback, loads and stores
//   issue a single data-bus request and wait for its completion. Misaligned
//   accesses are rejected with a one-cycle misalign pulse.
//   Ports:
//     clk, reset                  : clock, asynchronous active-high reset
//     in_valid/in_ready           : upstream handshake
//     in_op, in_rd, in_alu_result : op class, destination, value/address
//     in_store_data, in_size      : store data, access width
//     in_unsigned                 : zero-extend loads
//     dreq_valid/write/addr       : data-bus request
//     dreq_strobe/wdata           : byte-lane enables, lane-aligned store data
//     dresp_valid/dresp_data      : data-bus completion and read data
//     rf_we/rf_rd/rf_wd           : register-file write port
//     misalign                    : rejected-access pulse
//     busy                        : unit not idle
// ---------------------------------------------------------------------------
module mem_wb_unit
    import common::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  op_t         in_op,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_alu_result,
    input  logic [63:0] in_store_data,
    input  msize_t      in_size,
    input  logic        in_unsigned,

    output logic        dreq_valid,
    output logic        dreq_write,
    output logic [63:0] dreq_addr,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_wdata,
    input  logic        dresp_valid,
    input  logic [63:0] dresp_data,

    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [63:0] rf_wd,

    output logic        misalign,
    output logic        busy
);

    state_t      state_q, state_d;

    op_t         op_q;
    logic [4:0]  rd_q;
    logic [63:0] addr_q;
    logic [7:0]  strobe_q;
    logic [63:0] wdata_q;
    msize_t      size_q;
    logic        unsigned_q;
    logic [63:0] wb_data_q;
    logic        misalign_q;

    logic        accept;
    logic        in_mis;
    logic        in_is_mem;
    logic [63:0] load_value;

    // in_ready is masked while reset is held so nothing is accepted then.
    assign in_ready  = (state_q == ST_IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign in_is_mem = (in_op == OP_LOAD) || (in_op == OP_STORE);
    assign in_mis    = in_is_mem && is_misaligned(in_size, in_alu_result[2:0]);

    mem_extend u_extend (
        .data_i     (dresp_data),
        .offset_i   (addr_q[2:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .result_o   (load_value)
    );

    // State register: async reset also drops dreq_valid immediately since
    // the request is decoded from the MEM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_op == OP_ALU) begin
                        state_d = ST_WB;
                    end else if (!in_mis) begin
                        state_d = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                if (dresp_valid) begin
                    state_d = (op_q == OP_LOAD) ? ST_WB : ST_IDLE;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latched transaction fields. Strobe and store data are lane-aligned at
    // accept so they are constant for the whole MEM phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= OP_ALU;
            rd_q       <= 5'd0;
            addr_q     <= 64'd0;
            strobe_q   <= 8'd0;
            wdata_q    <= 64'd0;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            wb_data_q  <= 64'd0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && in_mis;
            if (accept) begin
                op_q       <= in_op;
                rd_q       <= in_rd;
                addr_q     <= in_alu_result;
                strobe_q   <= size_mask(in_size) << in_alu_result[2:0];
                wdata_q    <= in_store_data << {in_alu_result[2:0], 3'b000};
                size_q     <= in_size;
                unsigned_q <= in_unsigned;
                wb_data_q  <= in_alu_result;
            end else if ((state_q == ST_MEM) && dresp_valid && (op_q == OP_LOAD)) begin
                wb_data_q  <= load_value;
            end
        end
    end

    assign dreq_valid  = (state_q == ST_MEM);
    assign dreq_write  = (state_q == ST_MEM) && (op_q == OP_STORE);
    assign dreq_addr   = addr_q;
    assign dreq_strobe = strobe_q;
    assign dreq_wdata  = wdata_q;

    // x0 is never written, but the sequencer still spends the WB cycle.
    assign rf_we = (state_q == ST_WB) && (rd_q != 5'd0);
    assign rf_rd = rd_q;
    assign rf_wd = wb_data_q;

    assign misalign = misalign_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_wb_unit.sv
module tb_mem_wb_unit;
    import common::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    op_t         in_op;
    logic [4:0]  in_rd;
    logic [63:0] in_alu_result;
    logic [63:0] in_store_data;
    msize_t      in_size;
    logic        in_unsigned;
    logic        dreq_valid;
    logic        dreq_write;
    logic [63:0] dreq_addr;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_wdata;
    logic        dresp_valid;
    logic [63:0] dresp_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wd;
    logic        misalign;
    logic        busy;

    int passed;
    int total;

    mem_wb_unit dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_size       (in_size),
        .in_unsigned   (in_unsigned),
        .dreq_valid    (dreq_valid),
        .dreq_write    (dreq_write),
        .dreq_addr     (dreq_addr),
        .dreq_strobe   (dreq_strobe),
        .dreq_wdata    (dreq_wdata),
        .dresp_valid   (dresp_valid),
        .dresp_data    (dresp_data),
        .rf_we         (rf_we),
        .rf_rd         (rf_rd),
        .rf_wd         (rf_wd),
        .misalign      (misalign),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: plain byte arithmetic ----
    function automatic int nbytes(input msize_t s);
        case (s)
            SIZE_B:  return 1;
            SIZE_H:  return 2;
            SIZE_W:  return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit model_mis(input msize_t s, input logic [63:0] a);
        return (a % nbytes(s)) != 0;
    endfunction

    function automatic logic [7:0] model_strobe(input msize_t s, input logic [63:0] a);
        int unsigned lanes;
        lanes = ((1 << nbytes(s)) - 1) << (a % 8);
        return lanes[7:0];
    endfunction

    function automatic logic [63:0] model_load(input msize_t s, input logic [63:0] a,
                                               input logic [63:0] d, input bit uns);
        logic [63:0] sh, keep, v;
        int n;
        n  = nbytes(s);
        sh = d >> (8 * (a % 8));
        if (n == 8) return sh;
        keep = (64'd1 << (8 * n)) - 64'd1;
        v    = sh & keep;
        if (!uns && sh[8*n-1]) v = v | ~keep;
        return v;
    endfunction

    // One complete transaction: offer, then follow it to idle while checking.
    task automatic txn(input op_t op, input logic [4:0] rd, input logic [63:0] addr,
                       input logic [63:0] sd, input msize_t sz, input bit uns,
                       input int waits, input logic [63:0] rdata);
        chk("ready_before_offer", 64'(in_ready), 64'd1);
        in_valid      = 1'b1;
        in_op         = op;
        in_rd         = rd;
        in_alu_result = addr;
        in_store_data = sd;
        in_size       = sz;
        in_unsigned   = uns;
        cyc();
        in_valid = 1'b0;
        if (op == OP_ALU) begin
            chk("alu_we", 64'(rf_we), 64'(rd != 0));
            chk("alu_rd", 64'(rf_rd), 64'(rd));
            chk("alu_wd", rf_wd, addr);
            chk("alu_ready_low", 64'(in_ready), 64'd0);
            cyc();
            chk("alu_we_after", 64'(rf_we), 64'd0);
            chk("alu_ready_back", 64'(in_ready), 64'd1);
        end else if (model_mis(sz, addr)) begin
            chk("mis_pulse", 64'(misalign), 64'd1);
            chk("mis_no_req", 64'(dreq_valid), 64'd0);
            chk("mis_idle", 64'(busy), 64'd0);
            cyc();
            chk("mis_pulse_end", 64'(misalign), 64'd0);
            chk("mis_no_req2", 64'(dreq_valid), 64'd0);
            chk("mis_no_we", 64'(rf_we), 64'd0);
        end else begin
            for (int w = 0; w <= waits; w++) begin
                chk("req_valid", 64'(dreq_valid), 64'd1);
                chk("req_write", 64'(dreq_write), 64'(op == OP_STORE));
                chk("req_addr", dreq_addr, addr);
                chk("req_strobe", 64'(dreq_strobe), 64'(model_strobe(sz, addr)));
                if (op == OP_STORE)
                    chk("req_wdata", dreq_wdata, sd << (8 * (addr % 8)));
                chk("req_no_we", 64'(rf_we), 64'd0);
                if (w == waits) begin
                    dresp_valid = 1'b1;
                    dresp_data  = rdata;
                end
                cyc();
            end
            dresp_valid = 1'b0;
            dresp_data  = 64'd0;
            chk("resp_req_drop", 64'(dreq_valid), 64'd0);
            if (op == OP_LOAD) begin
                chk("ld_busy_wb", 64'(busy), 64'd1);
                chk("ld_we", 64'(rf_we), 64'(rd != 0));
                chk("ld_rd", 64'(rf_rd), 64'(rd));
                if (rd != 0) chk("ld_wd", rf_wd, model_load(sz, addr, rdata, uns));
                cyc();
            end
            chk("end_idle", 64'(busy), 64'd0);
            chk("end_no_we", 64'(rf_we), 64'd0);
        end
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_op         = OP_ALU;
        in_rd         = 5'd0;
        in_alu_result = 64'd0;
        in_store_data = 64'd0;
        in_size       = SIZE_B;
        in_unsigned   = 1'b0;
        dresp_valid   = 1'b0;
        dresp_data    = 64'd0;

        // Reset state
        repeat (3) cyc();
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_req", 64'(dreq_valid), 64'd0);
        chk("rst_mis", 64'(misalign), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wd", rf_wd, 64'd0);
        chk("rst_addr", dreq_addr, 64'd0);
        chk("rst_strobe", 64'(dreq_strobe), 64'd0);
        reset = 1'b0;
        cyc();
        chk("rst_ready_after", 64'(in_ready), 64'd1);

        // Directed cases
        txn(OP_ALU,   5'd5, 64'h1234, 64'd0, SIZE_D, 1'b0, 0, 64'd0);
        txn(OP_LOAD,  5'd3, 64'h1003, 64'd0, SIZE_B, 1'b0, 3, 64'h00000000_80000000);
        txn(OP_LOAD,  5'd7, 64'h1006, 64'd0, SIZE_H, 1'b1, 1, 64'hBEEF0000_00000000);
        txn(OP_STORE, 5'd4, 64'h2004, 64'hDEADBEEF, SIZE_W, 1'b0, 2, 64'd0);
        txn(OP_LOAD,  5'd8, 64'h3004, 64'd0, SIZE_D, 1'b0, 0, 64'd0);
        txn(OP_LOAD,  5'd9, 64'h4008, 64'd0, SIZE_D, 1'b1, 0, 64'hFEDCBA98_76543210);

        // Explicit values for the directed load/store cases
        chk("lb_model", model_load(SIZE_B, 64'h1003, 64'h80000000, 1'b0), 64'hFFFFFFFF_FFFFFF80);
        chk("lhu_model", model_load(SIZE_H, 64'h1006, 64'hBEEF0000_00000000, 1'b1), 64'h0000BEEF);

        // rd = 0 load still passes through WB but writes nothing
        txn(OP_LOAD, 5'd0, 64'h5000, 64'd0, SIZE_W, 1'b0, 0, 64'h12345678);

        // Completion outside MEM is ignored
        dresp_valid = 1'b1;
        dresp_data  = 64'hFFFF;
        cyc();
        cyc();
        dresp_valid = 1'b0;
        chk("stray_resp_idle", 64'(busy), 64'd0);
        chk("stray_resp_we", 64'(rf_we), 64'd0);

        // Reset while a load is waiting on the bus
        in_valid      = 1'b1;
        in_op         = OP_LOAD;
        in_rd         = 5'd9;
        in_alu_result = 64'h6000;
        in_size       = SIZE_D;
        cyc();
        in_valid = 1'b0;
        chk("rstmem_req", 64'(dreq_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("rstmem_async_drop", 64'(dreq_valid), 64'd0);
        cyc();
        reset       = 1'b0;
        dresp_valid = 1'b1;
        dresp_data  = 64'h1111;
        cyc();
        dresp_valid = 1'b0;
        chk("rstmem_idle", 64'(busy), 64'd0);
        chk("rstmem_no_we", 64'(rf_we), 64'd0);
        cyc();
        chk("rstmem_no_we2", 64'(rf_we), 64'd0);
        chk("rstmem_ready", 64'(in_ready), 64'd1);

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            op_t         op;
            msize_t      sz;
            logic [63:0] a, d, s;
            op = op_t'($urandom_range(0, 2));
            sz = msize_t'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            d  = {$urandom, $urandom};
            s  = {$urandom, $urandom};
            // bias toward aligned accesses so most reach the bus
            if ($urandom_range(0, 3) != 0) a = a & ~(64'(nbytes(sz)) - 64'd1);
            txn(op, 5'($urandom_range(0, 31)), a, s, sz, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), d);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
